// File: rtl/sram_arb_pkg.sv
// Shared definitions for the SRAM arbiter: FSM state encoding, grant codes
// and the default SRAM address width.
package sram_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [1:0] GNT_NONE = 2'd0;
    localparam logic [1:0] GNT_VID  = 2'd1;
    localparam logic [1:0] GNT_CPU  = 2'd2;
    localparam logic [1:0] GNT_DMA  = 2'd3;

    localparam int ADDR_W_DEF = 21;

endpackage

// File: rtl/sram_arb_pick.sv
// Combinational winner selection: video first unless it has hit its streak cap
// while others wait, then CPU/DMA round-robin.
module sram_arb_pick
    import sram_arb_pkg::*;
#(
    parameter int VID_MAX = 8,
    parameter int CNT_W   = 4
) (
    input  logic             vid_req,
    input  logic             cpu_req,
    input  logic             dma_req,
    input  logic [CNT_W-1:0] vid_cnt,
    input  logic             rr_last_dma,
    output logic [1:0]       win
);

    logic others;

    always_comb begin
        others = cpu_req | dma_req;
        win    = GNT_NONE;
        if (vid_req && ((vid_cnt < CNT_W'(VID_MAX)) || !others))
            win = GNT_VID;
        else if (cpu_req && dma_req)
            win = rr_last_dma ? GNT_CPU : GNT_DMA;
        else if (cpu_req)
            win = GNT_CPU;
        else if (dma_req)
            win = GNT_DMA;
    end

endmodule

// File: rtl/sram_arbiter.sv
// Three-way arbiter for the shared 8-bit async SRAM; owns every SRAM pin and
// runs each access as IDLE -> ACC (ACC_CYC cycles) -> DONE.
module sram_arbiter
    import sram_arb_pkg::*;
#(
    parameter  int ADDR_W  = ADDR_W_DEF,
    parameter  int ACC_CYC = 2,
    parameter  int VID_MAX = 8,
    localparam int CNT_W   = $clog2(VID_MAX + 1)
) (
    input  logic              clk,
    input  logic              reset_n,
    // Handshake: a requester raises req with addr/we/wdata and holds them until
    // its one-cycle ack; they are latched at grant, and a req still high in the
    // cycle after ack is taken as a fresh request.
    input  logic              vid_req,
    input  logic [ADDR_W-1:0] vid_addr,
    output logic              vid_ack,
    output logic [7:0]        vid_rdata,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [7:0]        cpu_wdata,
    output logic              cpu_ack,
    output logic [7:0]        cpu_rdata,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [7:0]        dma_wdata,
    output logic              dma_ack,
    output logic [7:0]        dma_rdata,
    output logic [ADDR_W-1:0] sram_a,
    input  logic [7:0]        sram_d_in,
    output logic [7:0]        sram_d_out,
    output logic              sram_d_oe,
    output logic              sram_we_n,
    output logic [1:0]        grant,
    output state_t            dbg_state,
    output logic [CNT_W-1:0]  dbg_vid_cnt
);

    state_t           state;
    logic [3:0]       cyc;
    logic             acc_we;
    logic [CNT_W-1:0] vid_cnt;
    logic             rr_last_dma;
    logic [1:0]       pick;

    sram_arb_pick #(
        .VID_MAX (VID_MAX),
        .CNT_W   (CNT_W)
    ) u_pick (
        .vid_req     (vid_req),
        .cpu_req     (cpu_req),
        .dma_req     (dma_req),
        .vid_cnt     (vid_cnt),
        .rr_last_dma (rr_last_dma),
        .win         (pick)
    );

    assign dbg_state   = state;
    assign dbg_vid_cnt = vid_cnt;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            cyc         <= 4'd0;
            acc_we      <= 1'b0;
            sram_a      <= '0;
            sram_d_out  <= 8'd0;
            sram_d_oe   <= 1'b0;
            sram_we_n   <= 1'b1;
            vid_ack     <= 1'b0;
            cpu_ack     <= 1'b0;
            dma_ack     <= 1'b0;
            vid_rdata   <= 8'd0;
            cpu_rdata   <= 8'd0;
            dma_rdata   <= 8'd0;
            grant       <= GNT_NONE;
            vid_cnt     <= '0;
            rr_last_dma <= 1'b0;
        end else begin
            vid_ack <= 1'b0;
            cpu_ack <= 1'b0;
            dma_ack <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (pick != GNT_NONE) begin
                        state <= ST_ACC;
                        cyc   <= 4'd0;
                        grant <= pick;
                        case (pick)
                            GNT_VID: begin
                                sram_a    <= vid_addr;
                                acc_we    <= 1'b0;
                                sram_d_oe <= 1'b0;
                                if (vid_cnt < CNT_W'(VID_MAX))
                                    vid_cnt <= vid_cnt + CNT_W'(1);
                            end
                            GNT_CPU: begin
                                sram_a      <= cpu_addr;
                                acc_we      <= cpu_we;
                                sram_d_oe   <= cpu_we;
                                if (cpu_we)
                                    sram_d_out <= cpu_wdata;
                                vid_cnt     <= '0;
                                rr_last_dma <= 1'b0;
                            end
                            default: begin
                                sram_a      <= dma_addr;
                                acc_we      <= dma_we;
                                sram_d_oe   <= dma_we;
                                if (dma_we)
                                    sram_d_out <= dma_wdata;
                                vid_cnt     <= '0;
                                rr_last_dma <= 1'b1;
                            end
                        endcase
                    end
                end
                ST_ACC: begin
                    if (cyc == 4'(ACC_CYC - 1)) begin
                        // WE_n rises here while data is still driven: hold time.
                        state     <= ST_DONE;
                        sram_we_n <= 1'b1;
                        case (grant)
                            GNT_VID: begin
                                vid_ack   <= 1'b1;
                                vid_rdata <= sram_d_in;
                            end
                            GNT_CPU: begin
                                cpu_ack <= 1'b1;
                                if (!acc_we)
                                    cpu_rdata <= sram_d_in;
                            end
                            default: begin
                                dma_ack <= 1'b1;
                                if (!acc_we)
                                    dma_rdata <= sram_d_in;
                            end
                        endcase
                    end else begin
                        cyc       <= cyc + 4'd1;
                        sram_we_n <= !acc_we;
                    end
                end
                ST_DONE: begin
                    state     <= ST_IDLE;
                    sram_d_oe <= 1'b0;
                    grant     <= GNT_NONE;
                end
                default: begin
                    state     <= ST_IDLE;
                    sram_we_n <= 1'b1;
                    sram_d_oe <= 1'b0;
                    grant     <= GNT_NONE;
                end
            endcase
        end
    end

endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
Shares the single 8-bit asynchronous SRAM (21-bit address, one WE_n) between three requesters: video line fetch, CPU bus, and DMA (SD/audio).
- Owns every SRAM pin and sequences each access as fixed setup/strobe cycles.
- Arbitrates with video-first priority plus a starvation cap, and round-robin between CPU and DMA.
- Sits between system_2MB's bus masters and the top-level SRAM pins. The top level merges sram_d_out/sram_d_oe into the inout bus.

Parameters:
ADDR_W, 21, SRAM address width
ACC_CYC, 2, cycles per access (legal range 2..15)
VID_MAX, 8, maximum consecutive video grants while another requester is waiting

Ports:
clk  in  1  system clock (sram clock domain)
reset_n  in  1  synchronous reset, active low
vid_req  in  1  video read request, held until vid_ack
vid_addr  in  ADDR_W  video read address
vid_ack  out  1  one-cycle pulse; vid_rdata valid in the same cycle
vid_rdata  out  8  video read data
cpu_req  in  1  CPU request, held until cpu_ack
cpu_we  in  1  1 = write, 0 = read
cpu_addr  in  ADDR_W  CPU address
cpu_wdata  in  8  CPU write data
cpu_ack  out  1  one-cycle completion pulse
cpu_rdata  out  8  CPU read data, valid with cpu_ack
dma_req, dma_we, dma_addr, dma_wdata, dma_ack, dma_rdata  same widths/meaning as the cpu_* ports
sram_a  out  ADDR_W  SRAM address
sram_d_in  in  8  SRAM data from pad
sram_d_out  out  8  SRAM data to pad
sram_d_oe  out  1  pad output enable
sram_we_n  out  1  SRAM write strobe, active low
grant  out  2  current owner: 0 none, 1 video, 2 CPU, 3 DMA

Behaviour:
- Reset values (reset_n low at a clk edge): state IDLE, sram_we_n=1, sram_d_oe=0, sram_a=0, sram_d_out=0, all *_ack=0, all *_rdata=0, grant=0, vid_cnt=0, rr_last=CPU.
- Reset mid-access aborts the access. No ack is issued for it, and sram_we_n=1 on the following cycle.
- States:
  - IDLE: sample requests, choose a winner, latch its addr/we/wdata. Go to ACC with cyc=0, or stay in IDLE if there are no requests.
  - ACC: cyc counts 0..ACC_CYC-1. After cyc=ACC_CYC-1, go to DONE.
  - DONE: pulse the winner's ack for 1 cycle, then go to IDLE.
- Throughput is one access per ACC_CYC+2 cycles. Latency from req seen in IDLE to ack is ACC_CYC+1 cycles.
- Priority, evaluated only in IDLE:
  - Video wins if vid_req=1 and either vid_cnt<VID_MAX or no other request is pending.
  - Otherwise CPU/DMA round-robin: the one not granted last wins; a lone requester wins.
  - vid_cnt increments on each video grant (saturating at VID_MAX) and clears on any CPU/DMA grant.
- Access timing:
  - sram_a is driven from the IDLE→ACC edge and held until the next grant, including through DONE.
  - Write: sram_d_oe=1 and sram_d_out=wdata from cyc 0. sram_we_n=0 during cyc 1..ACC_CYC-1 only.
  - sram_d_oe stays 1 through DONE and is cleared at the next read grant or in IDLE. This gives hold time after WE_n rises.
  - Read: sram_d_oe=0. Data is sampled from sram_d_in on the ACC→DONE edge into the winner's rdata register. The other requesters' rdata registers are unchanged.
- Handshake rules:
  - Requesters hold req, addr, we and wdata stable until ack. The arbiter latches them at grant anyway.
  - A req dropped mid-access does not cancel the access; the ack still pulses.
  - A req still high in the cycle after ack is treated as a new request.
  - Video writes do not exist.
  - Simultaneous requests are resolved by the priority rules above only; no acks collide.
- Widths: cyc is 4 bits; vid_cnt is clog2(VID_MAX+1) bits.

Decomposition:
- Package sram_arb_pkg holds:
  - the state encoding (IDLE, ACC, DONE);
  - grant codes (GNT_NONE=0, GNT_VID=1, GNT_CPU=2, GNT_DMA=3);
  - the ADDR_W default.
- One sub-module, sram_arb_pick: combinational winner selection from req vector, vid_cnt and rr_last. It is unit-testable apart from the timing FSM.

Test Plan:
- CPU write 0xA5 to 0x1F_FFFF, ACC_CYC=2: sram_a=0x1F_FFFF, sram_d_oe=1 at cycles 1-3, sram_we_n=0 only at cycle 2, cpu_ack at cycle 3, then IDLE.
- CPU read at 0x00_0010 with sram_d_in=0x3C: cpu_ack pulses ACC_CYC+1=3 cycles after the grant cycle, cpu_rdata=0x3C, sram_we_n stays 1 throughout.
- vid_req and cpu_req held continuously, VID_MAX=8: grant sequence is 8×video, 1×CPU, 8×video, …; vid_cnt clears on the CPU grant.
- cpu_req and dma_req held continuously, video idle: grants alternate CPU, DMA, CPU, DMA. With dma_req alone, DMA is granted back-to-back every 4 cycles.
- reset_n low during cyc 1 of a write: next cycle sram_we_n=1, sram_d_oe=0, grant=0, no cpu_ack; after release the held request is re-granted.
- Read with ACC_CYC=5 and video alone: vid_ack every 7 cycles, vid_cnt saturates at 8, video still granted with no other requester pending.
